// File: rtl/data_mem_responder.sv
// Word-addressed data memory slave with a configurable wait-state count, byte-lane writes and
// an out-of-range error response. Each request runs IDLE -> (WAIT) -> RESP -> IDLE.
module data_mem_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        wr,
  input  logic [3:0]  mask,
  input  logic [31:0] addr,
  input  logic [31:0] data_wr,
  output logic [31:0] data_rd,
  output logic        stall,
  output logic        err
);

  localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0]  CNT_INIT = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;
  localparam logic        NO_WAIT  = (WAIT_STATES == 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic [1:0]  r_cnt;
  logic        r_wr;
  logic [3:0]  r_mask;
  logic [29:0] r_word;
  logic [31:0] r_data;
  logic [31:0] r_data_rd;
  logic        r_err;

  logic [31:0] r_mem [DEPTH];

  logic             w_accept;
  logic             w_enter_resp;
  logic             w_req_wr;
  logic [3:0]       w_req_mask;
  logic [29:0]      w_req_word;
  logic [31:0]      w_req_data;
  logic             w_oor;
  logic [IDX_W-1:0] w_idx;
  logic             w_commit_wr;
  logic             w_unused_addr_lsb;

  assign w_unused_addr_lsb = ^addr[1:0];

  // With no wait states the accept edge is also the edge entering RESP, so the live request
  // inputs are used in IDLE and the latched copy otherwise.
  assign w_accept     = (r_state == S_IDLE) && !cs;
  assign w_enter_resp = (w_accept && NO_WAIT) || ((r_state == S_WAIT) && (r_cnt == 2'd0));
  assign w_req_wr     = (r_state == S_IDLE) ? wr         : r_wr;
  assign w_req_mask   = (r_state == S_IDLE) ? mask       : r_mask;
  assign w_req_word   = (r_state == S_IDLE) ? addr[31:2] : r_word;
  assign w_req_data   = (r_state == S_IDLE) ? data_wr    : r_data;
  assign w_oor        = ({1'b0, w_req_word} >= 31'(DEPTH));
  assign w_idx        = w_req_word[IDX_W-1:0];
  assign w_commit_wr  = w_enter_resp && !w_req_wr && !w_oor && rst;

  assign stall   = ((r_state == S_IDLE) && !cs) || (r_state == S_WAIT);
  assign data_rd = r_data_rd;
  assign err     = r_err;

  // Control state, request latch and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 2'd0;
      r_wr      <= 1'b0;
      r_mask    <= 4'd0;
      r_word    <= 30'd0;
      r_data    <= 32'd0;
      r_data_rd <= 32'd0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!cs) begin
            r_wr   <= wr;
            r_mask <= mask;
            r_word <= addr[31:2];
            r_data <= data_wr;
            if (NO_WAIT) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 2'd0) begin
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      r_err <= w_enter_resp && w_oor;
      if (w_enter_resp && (w_req_wr || w_oor)) begin
        r_data_rd <= w_oor ? 32'd0 : r_mem[w_idx];
      end
    end
  end

  // Backing array: byte-lane writes, never cleared by reset.
  always_ff @(posedge clk) begin
    if (w_commit_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (w_req_mask[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_req_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (0, 2 and 3 wait states) driven from one
// initial block, with a reference memory model feeding a scoreboard of expected responses.
module tb_data_mem_responder;

  typedef struct {
    int          stalls;
    logic        err;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    int          stalls;
    logic        err;
    logic [31:0] data;
    logic        werr;
    logic        idle_busy;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_a   [3];
  logic        cs_a    [3];
  logic        wr_a    [3];
  logic [3:0]  mask_a  [3];
  logic [31:0] addr_a  [3];
  logic [31:0] dwr_a   [3];
  logic [31:0] drd_a   [3];
  logic        stall_a [3];
  logic        err_a   [3];

  int          ws_tab [3] = '{0, 2, 3};
  logic [31:0] model  [3][1024];
  logic [31:0] last_rd[3];
  exp_t        sb_exp [$];
  obs_t        sb_obs [$];
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(1024), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst_a[0]), .cs(cs_a[0]), .wr(wr_a[0]), .mask(mask_a[0]), .addr(addr_a[0]),
    .data_wr(dwr_a[0]), .data_rd(drd_a[0]), .stall(stall_a[0]), .err(err_a[0]));

  data_mem_responder #(.DEPTH(1024), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .rst(rst_a[1]), .cs(cs_a[1]), .wr(wr_a[1]), .mask(mask_a[1]), .addr(addr_a[1]),
    .data_wr(dwr_a[1]), .data_rd(drd_a[1]), .stall(stall_a[1]), .err(err_a[1]));

  data_mem_responder #(.DEPTH(1024), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst_a[2]), .cs(cs_a[2]), .wr(wr_a[2]), .mask(mask_a[2]), .addr(addr_a[2]),
    .data_wr(dwr_a[2]), .data_rd(drd_a[2]), .stall(stall_a[2]), .err(err_a[2]));

  // One access on instance d: predict the response, drive it, collect what the DUT returned.
  task automatic issue(input int d, input logic w, input logic [3:0] m,
                       input logic [31:0] a, input logic [31:0] dw);
    exp_t        e;
    obs_t        o;
    logic [29:0] wi;
    int          n;
    wi       = a[31:2];
    e.stalls = 1 + ws_tab[d];
    e.err    = (wi >= 30'd1024);
    if (e.err) begin
      e.data     = 32'd0;
      last_rd[d] = 32'd0;
    end else if (w) begin
      e.data     = model[d][wi[9:0]];
      last_rd[d] = e.data;
    end else begin
      for (int i = 0; i < 4; i++)
        if (m[i]) model[d][wi[9:0]][8*i +: 8] = dw[8*i +: 8];
      e.data = last_rd[d];
    end
    sb_exp.push_back(e);

    cs_a[d] = 1'b0; wr_a[d] = w; mask_a[d] = m; addr_a[d] = a; dwr_a[d] = dw;
    #1;
    n      = 0;
    o.werr = 1'b0;
    while (stall_a[d] === 1'b1 && n < 12) begin
      o.werr = o.werr | err_a[d];
      n++;
      @(negedge clk); #1;
    end
    o.stalls = n;
    o.err    = err_a[d];
    o.data   = drd_a[d];
    // Garbage on the request lines during RESP must be ignored.
    cs_a[d] = 1'b1; wr_a[d] = ~w; mask_a[d] = ~m; addr_a[d] = ~a; dwr_a[d] = ~dw;
    @(negedge clk); #1;
    o.idle_busy = err_a[d] | stall_a[d];
    sb_obs.push_back(o);
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      rst_a[d] = 1'b0; cs_a[d] = 1'b1; wr_a[d] = 1'b1; mask_a[d] = 4'h0;
      addr_a[d] = 32'h0; dwr_a[d] = 32'h0; last_rd[d] = 32'h0;
    end
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      checks += 3;
      if (stall_a[d] !== 1'b0) begin failures++; $display("FAIL reset_stall[%0d] got=%b want=0", d, stall_a[d]); end
      if (err_a[d] !== 1'b0) begin failures++; $display("FAIL reset_err[%0d] got=%b want=0", d, err_a[d]); end
      if (drd_a[d] !== 32'h0) begin failures++; $display("FAIL reset_data_rd[%0d] got=%h want=0", d, drd_a[d]); end
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) rst_a[d] = 1'b1;
    #1;
  endtask

  task automatic test_store_load();
    exp_t e; obs_t o;
    issue(0, 1'b0, 4'hF, 32'h10, 32'hDEADBEEF);
    issue(0, 1'b1, 4'h0, 32'h10, 32'h0);
    while (sb_exp.size() != 0 && sb_obs.size() != 0) begin
      e = sb_exp.pop_front(); o = sb_obs.pop_front();
      checks += 5;
      if (o.stalls !== e.stalls) begin failures++; $display("FAIL store_load stall_cycles got=%0d want=%0d", o.stalls, e.stalls); end
      if (o.err !== e.err) begin failures++; $display("FAIL store_load err got=%b want=%b", o.err, e.err); end
      if (o.data !== e.data) begin failures++; $display("FAIL store_load data_rd got=%h want=%h", o.data, e.data); end
      if (o.werr !== 1'b0) begin failures++; $display("FAIL store_load err_while_stalled got=%b want=0", o.werr); end
      if (o.idle_busy !== 1'b0) begin failures++; $display("FAIL store_load idle_after_resp got=%b want=0", o.idle_busy); end
    end
  endtask

  task automatic test_byte_lanes();
    exp_t e; obs_t o;
    issue(0, 1'b0, 4'hF, 32'h10, 32'h11223344);
    issue(0, 1'b0, 4'h8, 32'h13, 32'hAB000000);
    issue(0, 1'b1, 4'h0, 32'h10, 32'h0);
    issue(0, 1'b0, 4'h0, 32'h10, 32'hFFFFFFFF);
    issue(0, 1'b1, 4'hF, 32'h12, 32'h0);
    issue(0, 1'b0, 4'h5, 32'h10, 32'h00660077);
    issue(0, 1'b1, 4'h3, 32'h10, 32'h0);
    while (sb_exp.size() != 0 && sb_obs.size() != 0) begin
      e = sb_exp.pop_front(); o = sb_obs.pop_front();
      checks += 3;
      if (o.stalls !== e.stalls) begin failures++; $display("FAIL byte_lanes stall_cycles got=%0d want=%0d", o.stalls, e.stalls); end
      if (o.err !== e.err) begin failures++; $display("FAIL byte_lanes err got=%b want=%b", o.err, e.err); end
      if (o.data !== e.data) begin failures++; $display("FAIL byte_lanes data_rd got=%h want=%h", o.data, e.data); end
    end
  endtask

  task automatic test_out_of_range();
    exp_t e; obs_t o;
    issue(0, 1'b0, 4'hF, 32'h0, 32'hCAFEF00D);
    issue(0, 1'b0, 4'hF, 32'hFFC, 32'h600DF00D);
    issue(0, 1'b0, 4'hF, 32'h1000, 32'h12345678);
    issue(0, 1'b1, 4'hF, 32'h1000, 32'h0);
    issue(0, 1'b1, 4'h0, 32'h0, 32'h0);
    issue(0, 1'b1, 4'h0, 32'hFFC, 32'h0);
    issue(0, 1'b1, 4'h0, 32'h8000_0000, 32'h0);
    issue(2, 1'b1, 4'h0, 32'h1004, 32'h0);
    while (sb_exp.size() != 0 && sb_obs.size() != 0) begin
      e = sb_exp.pop_front(); o = sb_obs.pop_front();
      checks += 5;
      if (o.stalls !== e.stalls) begin failures++; $display("FAIL out_of_range stall_cycles got=%0d want=%0d", o.stalls, e.stalls); end
      if (o.err !== e.err) begin failures++; $display("FAIL out_of_range err got=%b want=%b", o.err, e.err); end
      if (o.data !== e.data) begin failures++; $display("FAIL out_of_range data_rd got=%h want=%h", o.data, e.data); end
      if (o.werr !== 1'b0) begin failures++; $display("FAIL out_of_range err_while_stalled got=%b want=0", o.werr); end
      if (o.idle_busy !== 1'b0) begin failures++; $display("FAIL out_of_range idle_after_resp got=%b want=0", o.idle_busy); end
    end
  endtask

  task automatic test_wait_states();
    exp_t e; obs_t o;
    issue(2, 1'b0, 4'hF, 32'h40, 32'h01020304);
    issue(2, 1'b1, 4'h0, 32'h40, 32'h0);
    issue(1, 1'b0, 4'hF, 32'h44, 32'hF0E0D0C0);
    issue(1, 1'b1, 4'h0, 32'h44, 32'h0);
    while (sb_exp.size() != 0 && sb_obs.size() != 0) begin
      e = sb_exp.pop_front(); o = sb_obs.pop_front();
      checks += 5;
      if (o.stalls !== e.stalls) begin failures++; $display("FAIL wait_states stall_cycles got=%0d want=%0d", o.stalls, e.stalls); end
      if (o.err !== e.err) begin failures++; $display("FAIL wait_states err got=%b want=%b", o.err, e.err); end
      if (o.data !== e.data) begin failures++; $display("FAIL wait_states data_rd got=%h want=%h", o.data, e.data); end
      if (o.werr !== 1'b0) begin failures++; $display("FAIL wait_states err_while_stalled got=%b want=0", o.werr); end
      if (o.idle_busy !== 1'b0) begin failures++; $display("FAIL wait_states idle_after_resp got=%b want=0", o.idle_busy); end
    end
  endtask

  task automatic test_reset_mid_access();
    exp_t e; obs_t o;
    issue(1, 1'b0, 4'hF, 32'h20, 32'hA5A5A5A5);
    issue(0, 1'b0, 4'hF, 32'h30, 32'h3C3C3C3C);
    // Abort a store while it sits in WAIT on the two-wait-state instance.
    cs_a[1] = 1'b0; wr_a[1] = 1'b0; mask_a[1] = 4'hF; addr_a[1] = 32'h20; dwr_a[1] = 32'h55555555;
    @(negedge clk); #1;
    checks++;
    if (stall_a[1] !== 1'b1) begin failures++; $display("FAIL reset_mid stall_in_wait got=%b want=1", stall_a[1]); end
    rst_a[1] = 1'b0; cs_a[1] = 1'b1;
    #1;
    checks += 3;
    if (stall_a[1] !== 1'b0) begin failures++; $display("FAIL reset_mid stall got=%b want=0", stall_a[1]); end
    if (err_a[1] !== 1'b0) begin failures++; $display("FAIL reset_mid err got=%b want=0", err_a[1]); end
    if (drd_a[1] !== 32'h0) begin failures++; $display("FAIL reset_mid data_rd got=%h want=0", drd_a[1]); end
    last_rd[1] = 32'h0;
    // Abort a zero-wait store during its accept cycle.
    cs_a[0] = 1'b0; wr_a[0] = 1'b0; mask_a[0] = 4'hF; addr_a[0] = 32'h30; dwr_a[0] = 32'h99999999;
    rst_a[0] = 1'b0;
    #1;
    cs_a[0] = 1'b1;
    last_rd[0] = 32'h0;
    @(negedge clk); #1;
    rst_a[0] = 1'b1; rst_a[1] = 1'b1;
    @(negedge clk); #1;
    issue(1, 1'b1, 4'h0, 32'h20, 32'h0);
    issue(0, 1'b1, 4'h0, 32'h30, 32'h0);
    while (sb_exp.size() != 0 && sb_obs.size() != 0) begin
      e = sb_exp.pop_front(); o = sb_obs.pop_front();
      checks += 3;
      if (o.stalls !== e.stalls) begin failures++; $display("FAIL reset_mid stall_cycles got=%0d want=%0d", o.stalls, e.stalls); end
      if (o.err !== e.err) begin failures++; $display("FAIL reset_mid err_resp got=%b want=%b", o.err, e.err); end
      if (o.data !== e.data) begin failures++; $display("FAIL reset_mid data_rd_resp got=%h want=%h", o.data, e.data); end
    end
  endtask

  task automatic test_idle_ignore();
    exp_t e; obs_t o;
    for (int c = 0; c < 10; c++) begin
      cs_a[0] = 1'b1; wr_a[0] = c[0]; mask_a[0] = 4'($urandom);
      addr_a[0] = 32'h10; dwr_a[0] = $urandom;
      @(negedge clk); #1;
      checks += 3;
      if (stall_a[0] !== 1'b0) begin failures++; $display("FAIL idle_ignore stall cyc=%0d got=%b want=0", c, stall_a[0]); end
      if (err_a[0] !== 1'b0) begin failures++; $display("FAIL idle_ignore err cyc=%0d got=%b want=0", c, err_a[0]); end
      if (drd_a[0] !== last_rd[0]) begin failures++; $display("FAIL idle_ignore data_rd cyc=%0d got=%h want=%h", c, drd_a[0], last_rd[0]); end
    end
    issue(0, 1'b1, 4'h0, 32'h10, 32'h0);
    while (sb_exp.size() != 0 && sb_obs.size() != 0) begin
      e = sb_exp.pop_front(); o = sb_obs.pop_front();
      checks += 2;
      if (o.err !== e.err) begin failures++; $display("FAIL idle_ignore err_resp got=%b want=%b", o.err, e.err); end
      if (o.data !== e.data) begin failures++; $display("FAIL idle_ignore array_word got=%h want=%h", o.data, e.data); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; obs_t o;
    issue(1, 1'b0, 4'hF, 32'h40, 32'h0BADCAFE);
    issue(1, 1'b1, 4'h0, 32'h40, 32'h0);
    issue(1, 1'b0, 4'h2, 32'h41, 32'h00007700);
    issue(1, 1'b1, 4'h0, 32'h40, 32'h0);
    for (int i = 0; i < 8; i++) issue(2, 1'b0, 4'hF, 32'h100 + 32'(4 * i), $urandom);
    for (int i = 0; i < 16; i++)
      issue(2, 1'($urandom_range(0, 1)), 4'($urandom), 32'h100 + 32'(4 * $urandom_range(0, 7)), $urandom);
    while (sb_exp.size() != 0 && sb_obs.size() != 0) begin
      e = sb_exp.pop_front(); o = sb_obs.pop_front();
      checks += 4;
      if (o.stalls !== e.stalls) begin failures++; $display("FAIL back_to_back stall_cycles got=%0d want=%0d", o.stalls, e.stalls); end
      if (o.err !== e.err) begin failures++; $display("FAIL back_to_back err got=%b want=%b", o.err, e.err); end
      if (o.data !== e.data) begin failures++; $display("FAIL back_to_back data_rd got=%h want=%h", o.data, e.data); end
      if (o.idle_busy !== 1'b0) begin failures++; $display("FAIL back_to_back idle_after_resp got=%b want=0", o.idle_busy); end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_lanes();
    test_out_of_range();
    test_wait_states();
    test_reset_mid_access();
    test_idle_ignore();
    test_back_to_back();
    checks++;
    if (sb_exp.size() != sb_obs.size()) begin
      failures++;
      $display("FAIL scoreboard_drain expected_left=%0d observed_left=%0d", sb_exp.size(), sb_obs.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
